msg_shift_dp: RTL and testbench

Message datapath for the digital modulation transmitter, controlled by the message-processing controller. It loads a parallel message on `Ld`, then while `En` is high it serialises the message MSB-first, holding each bit for a programmable number of clock cycles. It produces the `Co2` terminal pulse that returns the controller to its load state. `bit_out` feeds the downstream modulator.

---
 rtl/msg_shift_dp.sv | 50 +++++
 tb/tb_msg_shift_dp.sv | 111 +++++++++++
 2 files changed

// File: rtl/msg_shift_dp.sv
// msg_shift_dp: loads a parallel message and shifts it out MSB-first, holding each bit for BIT_CYCLES enabled cycles; ports clk/reset, Ld/En/msg_in in, bit_out/bit_valid/Co1/Co2/bit_cnt out
module msg_shift_dp #(
  parameter int MSG_W      = 8,
  parameter int BIT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Ld,
  input  logic                     En,
  input  logic [MSG_W-1:0]         msg_in,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     Co1,
  output logic                     Co2,
  output logic [$clog2(MSG_W)-1:0] bit_cnt
);
  localparam int BW = $clog2(MSG_W);
  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  logic [MSG_W-1:0] r_shreg;
  logic [PW-1:0]    r_pcnt;
  logic [BW-1:0]    r_bcnt;
  logic             w_last_p;
  logic             w_last_b;
  assign w_last_p  = r_pcnt == PW'(BIT_CYCLES - 1);
  assign w_last_b  = r_bcnt == BW'(MSG_W - 1);
  assign bit_valid = En & ~Ld;
  assign Co1       = bit_valid & w_last_p;
  assign Co2       = Co1 & w_last_b;
  assign bit_out   = r_shreg[MSG_W-1];
  assign bit_cnt   = r_bcnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_pcnt  <= '0;
      r_bcnt  <= '0;
    end else if (Ld) begin
      r_shreg <= msg_in;
      r_pcnt  <= '0;
      r_bcnt  <= '0;
    end else if (En) begin
      if (w_last_p) begin
        r_pcnt  <= '0;
        r_shreg <= {r_shreg[MSG_W-2:0], 1'b0};
        r_bcnt  <= w_last_b ? '0 : r_bcnt + BW'(1);
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_msg_shift_dp.sv
// tb_msg_shift_dp: table-driven directed checks of msg_shift_dp at BIT_CYCLES=4 and BIT_CYCLES=1
module tb_msg_shift_dp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst0 = 1'b1, ld0 = 1'b0, en0 = 1'b0;
  logic [7:0] msg0 = '0;
  logic       bo0, bv0, co1_0, co2_0;
  logic [2:0] bc0;
  logic       rst1 = 1'b1, ld1 = 1'b0, en1 = 1'b0;
  logic [7:0] msg1 = '0;
  logic       bo1, bv1, co1_1, co2_1;
  logic [2:0] bc1;
  msg_shift_dp #(.MSG_W(8), .BIT_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(rst0), .Ld(ld0), .En(en0), .msg_in(msg0),
    .bit_out(bo0), .bit_valid(bv0), .Co1(co1_0), .Co2(co2_0), .bit_cnt(bc0)
  );
  msg_shift_dp #(.MSG_W(8), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst1), .Ld(ld1), .En(en1), .msg_in(msg1),
    .bit_out(bo1), .bit_valid(bv1), .Co1(co1_1), .Co2(co2_1), .bit_cnt(bc1)
  );
  typedef struct {
    string      name;
    bit         dut;
    bit         chk;
    logic       rst, ld, en;
    logic [7:0] msg;
    logic [6:0] exp;
  } vec_t;
  vec_t tv[$];
  int n_vec = 0;
  int n_err = 0;
  function automatic void add(string nm, bit d, bit ck, logic r, logic l, logic e, logic [7:0] m,
                              logic o, logic v, logic a, logic b, logic [2:0] c);
    vec_t t;
    t.name = nm; t.dut = d; t.chk = ck; t.rst = r; t.ld = l; t.en = e; t.msg = m;
    t.exp = {o, v, a, b, c};
    tv.push_back(t);
  endfunction
  function automatic void add_en(string nm, logic [7:0] m, int cf, int ct);
    for (int c = cf; c <= ct; c++) begin
      int k = (c - 1) / 4;
      add(nm, 0, 1, 0, 0, 1, 8'h00, m[7-k], 1'b1, (c % 4) == 0, c == 32, 3'(k));
    end
  endfunction
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $finish;
  end
  initial begin
    add("rst_a", 0, 0, 1, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
    add("rst_b", 0, 1, 1, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
    add("rst_release", 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add("en_idle", 0, 1, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0);
    add("ld_a5", 0, 1, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 0);
    add_en("basic", 8'hA5, 1, 32);
    add("post_basic", 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add("ld_c3", 0, 1, 0, 1, 0, 8'hC3, 0, 0, 0, 0, 0);
    add_en("pause_pre", 8'hC3, 1, 10);
    for (int i = 0; i < 5; i++) add("frozen", 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2);
    add_en("pause_resume", 8'hC3, 11, 32);
    add("ld_5a", 0, 1, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 0);
    add_en("pre_collide", 8'h5A, 1, 31);
    add("collide", 0, 1, 0, 1, 1, 8'h81, 0, 0, 0, 0, 7);
    add_en("post_collide", 8'h81, 1, 32);
    add("ld_a5_b", 0, 1, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 0);
    add_en("pre_midrst", 8'hA5, 1, 12);
    add("mid_rst", 0, 1, 1, 0, 1, 8'h00, 0, 1, 0, 0, 3);
    add_en("after_rst", 8'h00, 1, 5);
    add("ld_fresh", 0, 1, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 1);
    add_en("fresh", 8'hA5, 1, 32);
    add("bc1_rst", 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add("bc1_ld", 1, 1, 0, 1, 0, 8'h01, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 16; c++)
      add("bc1_overrun", 1, 1, 0, 0, 1, 8'h00, c == 8, 1, 1, c == 8 || c == 16, 3'((c - 1) % 8));
    foreach (tv[i]) begin
      logic [6:0] got;
      @(negedge clk);
      if (tv[i].dut) begin
        rst1 = tv[i].rst; ld1 = tv[i].ld; en1 = tv[i].en; msg1 = tv[i].msg;
      end else begin
        rst0 = tv[i].rst; ld0 = tv[i].ld; en0 = tv[i].en; msg0 = tv[i].msg;
      end
      #2;
      got = tv[i].dut ? {bo1, bv1, co1_1, co2_1, bc1} : {bo0, bv0, co1_0, co2_0, bc0};
      if (tv[i].chk) begin
        n_vec++;
        if (got !== tv[i].exp) begin
          n_err++;
          $display("FAIL %s (vec %0d): {bit_out,bit_valid,Co1,Co2,bit_cnt} got %b expected %b",
                   tv[i].name, i, got, tv[i].exp);
        end
      end
    end
    @(negedge clk);
    rst0 = 1; ld0 = 1; en0 = 1; msg0 = 8'hFF;
    rst1 = 1; ld1 = 1; en1 = 1; msg1 = 8'hFF;
    repeat (2) @(negedge clk);
    rst0 = 0; ld0 = 0; en0 = 0; msg0 = 8'h00;
    rst1 = 0; ld1 = 0; en1 = 0; msg1 = 8'h00;
    #2;
    n_vec++;
    if ({bo0, bv0, co1_0, co2_0, bc0, bo1, bv1, co1_1, co2_1, bc1} !== 14'b0) begin
      n_err++;
      $display("FAIL final_reset: dut4 %b%b%b%b %b dut1 %b%b%b%b %b",
               bo0, bv0, co1_0, co2_0, bc0, bo1, bv1, co1_1, co2_1, bc1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
